// File: rtl/mem_pkg.sv
// Shared constants for the unified-memory response demux: destination
// select encodings and the default read-word width.
package mem_pkg;
  localparam logic SEL_IF  = 1'b0;
  localparam logic SEL_MEM = 1'b1;
  localparam int   DATA_W  = 32;
  localparam int   NUM_DST = 2;
endpackage

// File: rtl/mem_resp_demux_if.sv
// Request/response bundle between the memory return path and its two
// consumers. master drives requests and ready; slave is the demux.
interface mem_resp_demux_if #(parameter int n = 32);
  logic         req_valid;
  logic         req_sel;
  logic         req_ready;
  logic [n-1:0] resp_data;
  logic         if_valid;
  logic [n-1:0] if_data;
  logic         if_ready;
  logic         mem_valid;
  logic [n-1:0] mem_data;
  logic         mem_ready;

  modport master (
    output req_valid, req_sel, resp_data, if_ready, mem_ready,
    input  req_ready, if_valid, if_data, mem_valid, mem_data
  );

  modport slave (
    input  req_valid, req_sel, resp_data, if_ready, mem_ready,
    output req_ready, if_valid, if_data, mem_valid, mem_data
  );
endinterface

// File: rtl/mem_resp_slot.sv
// One-entry holding register for a single destination. free is high when
// the entry is empty or is being drained this cycle.
module mem_resp_slot #(parameter int n = 32) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [n-1:0] wr_data,
  input  logic         rd_ready,
  output logic         valid,
  output logic [n-1:0] data,
  output logic         free
);
  logic consume;

  assign consume = valid && rd_ready;
  assign free    = !valid || consume;

  // A write on the same edge as a drain wins, so the slot refills in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (wr_en) begin
      valid <= 1'b1;
      data  <= wr_data;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/mem_resp_demux.sv
// Routes the shared memory read word back to IF or MEM using a one-cycle
// in-flight tag. Optional MEM_RESP_DEMUX_BYPASS_EN forwards resp_data
// straight to an empty, ready destination in the capture cycle.
module mem_resp_demux
  import mem_pkg::*;
#(
  parameter int n = DATA_W
) (
  input logic             clk,
  input logic             rst,
  mem_resp_demux_if.slave bus
);
  logic                        tag_valid;
  logic                        tag_sel;
  logic                        accept;
  logic [NUM_DST-1:0]          rd_ready;
  logic [NUM_DST-1:0]          slot_valid;
  logic [NUM_DST-1:0]          slot_free;
  logic [NUM_DST-1:0]          wr_en;
  logic [NUM_DST-1:0]          byp;
  logic [NUM_DST-1:0]          out_valid;
  logic [NUM_DST-1:0][n-1:0]   slot_data;
  logic [NUM_DST-1:0][n-1:0]   out_data;

  assign rd_ready[SEL_IF]  = bus.if_ready;
  assign rd_ready[SEL_MEM] = bus.mem_ready;

  // Same-destination in-flight response blocks; the other destination does not.
  assign bus.req_ready = slot_free[bus.req_sel] && !(tag_valid && (tag_sel == bus.req_sel));
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_sel   <= SEL_IF;
    end else begin
      tag_valid <= accept;
      if (accept) tag_sel <= bus.req_sel;
    end
  end

  for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
    logic capture;

    assign capture = tag_valid && (tag_sel == 1'(d));

`ifdef MEM_RESP_DEMUX_BYPASS_EN
    assign byp[d]       = capture && !slot_valid[d] && rd_ready[d];
    assign out_valid[d] = slot_valid[d] || byp[d];
    assign out_data[d]  = byp[d] ? bus.resp_data : slot_data[d];
`else
    assign byp[d]       = 1'b0;
    assign out_valid[d] = slot_valid[d];
    assign out_data[d]  = slot_data[d];
`endif

    // A bypassed word is consumed directly and never lands in the slot.
    assign wr_en[d] = capture && !byp[d];

    mem_resp_slot #(.n(n)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en[d]),
      .wr_data  (bus.resp_data),
      .rd_ready (rd_ready[d]),
      .valid    (slot_valid[d]),
      .data     (slot_data[d]),
      .free     (slot_free[d])
    );
  end

  assign bus.if_valid  = out_valid[SEL_IF];
  assign bus.if_data   = out_data[SEL_IF];
  assign bus.mem_valid = out_valid[SEL_MEM];
  assign bus.mem_data  = out_data[SEL_MEM];
endmodule

// File: tb/tb_mem_resp_demux.sv
// Self-checking bench for mem_resp_demux: reset sequence, directed vector
// table, standalone slot refill sequence and randomized model comparison.
module tb_mem_resp_demux;
  import mem_pkg::*;

`ifdef MEM_RESP_DEMUX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_resp_demux_if #(.n(32)) bus ();

  mem_resp_demux #(.n(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic        s_rst, s_wr_en, s_rd_ready, s_valid, s_free;
  logic [31:0] s_wr_data, s_data;

  mem_resp_slot #(.n(32)) u_slot (
    .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .rd_ready(s_rd_ready), .valid(s_valid), .data(s_data), .free(s_free)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, rv, rs;
    logic [31:0] resp;
    logic        ir, mr;
    logic        e_rdy, e_ifv;
    logic [31:0] e_ifd;
    logic        e_memv;
    logic [31:0] e_memd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, rv, rs, input logic [31:0] resp, input logic ir, mr,
                     input logic erdy, eifv, input logic [31:0] eifd,
                     input logic ememv, input logic [31:0] ememd);
    vec_t v;
    v.rst = r; v.rv = rv; v.rs = rs; v.resp = resp; v.ir = ir; v.mr = mr;
    v.e_rdy = erdy; v.e_ifv = eifv; v.e_ifd = eifd; v.e_memv = ememv; v.e_memd = ememd;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic r, rv, rs, input logic [31:0] resp, input logic ir, mr);
    rst = r; bus.req_valid = rv; bus.req_sel = rs; bus.resp_data = resp;
    bus.if_ready = ir; bus.mem_ready = mr;
  endtask

  // Reference model state: per-destination holding slot plus the list of
  // requests whose data arrives next cycle.
  bit          m_v[2];
  logic [31:0] m_d[2];
  int          inflight[$];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin m_v[d] = 0; m_d[d] = '0; end
    inflight.delete();
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0);
    s_rst = 1; s_wr_en = 0; s_rd_ready = 0; s_wr_data = '0;

    // Reset with stray request activity.
    @(negedge clk); drive(1, 1, 0, 0, 1, 1);
    @(negedge clk); drive(1, 1, 1, 0, 1, 1);
    @(negedge clk); drive(0, 0, 0, 32'hDEADBEEF, 1, 1);
    #2;
    chk("rst_if_valid", 32'(bus.if_valid), 0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 0);
    chk("rst_if_data", bus.if_data, 0);
    chk("rst_mem_data", bus.mem_data, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1, 1);
    #2;
    chk("post_rst_if_valid", 32'(bus.if_valid), 0);
    chk("post_rst_mem_valid", 32'(bus.mem_valid), 0);

    //   rst rv rs resp          ir mr  rdy ifv            ifd           memv           memd
    add(0, 0, 0, 0,            1, 1,  1, 0,             0,            0,             0);
    add(0, 1, 0, 0,            0, 1,  1, 0,             0,            0,             0);
    add(0, 0, 0, 32'h00500093, 0, 1,  0, 0,             0,            0,             0);
    add(0, 0, 0, 0,            0, 1,  0, 1,  32'h00500093,            0,             0);
    add(0, 0, 0, 0,            1, 1,  1, 1,  32'h00500093,            0,             0);
    add(0, 1, 0, 0,            1, 1,  1, 0,             0,            0,             0);
    add(0, 1, 1, 32'h11,       1, 1,  1, BYP ? 1 : 0,   32'h11,       0,             0);
    add(0, 1, 0, 32'h22,       1, 1,  1, BYP ? 0 : 1,   32'h11,       BYP ? 1 : 0,   32'h22);
    add(0, 0, 0, 32'h33,       1, 1,  0, BYP ? 1 : 0,   32'h33,       BYP ? 0 : 1,   32'h22);
    add(0, 0, 0, 0,            1, 1,  1, BYP ? 0 : 1,   32'h33,       0,             0);
    add(0, 1, 1, 0,            1, 0,  1, 0,             0,            0,             0);
    add(0, 1, 1, 32'hCAFE,     1, 0,  0, 0,             0,            0,             0);
    add(0, 1, 1, 0,            1, 0,  0, 0,             0,            1,       32'hCAFE);
    add(0, 1, 0, 0,            1, 0,  1, 0,             0,            1,       32'hCAFE);
    add(0, 1, 1, 32'h5A5A,     0, 1,  1, 0,             0,            1,       32'hCAFE);
    add(0, 0, 0, 32'hA,        0, 0,  0, 1,       32'h5A5A,           0,             0);
    add(0, 0, 1, 0,            1, 1,  1, 1,       32'h5A5A,           1,          32'hA);
    add(0, 0, 0, 0,            1, 1,  1, 0,             0,            0,             0);
    add(0, 1, 0, 0,            0, 1,  1, 0,             0,            0,             0);
    add(1, 0, 0, 32'h77,       0, 1,  0, 0,             0,            0,             0);
    add(0, 0, 0, 32'h99,       0, 1,  1, 0,             0,            0,             0);
    add(0, 0, 0, 0,            0, 1,  1, 0,             0,            0,             0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rv, tbl[i].rs, tbl[i].resp, tbl[i].ir, tbl[i].mr);
      #2;
      chk($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_if_valid", i), 32'(bus.if_valid), 32'(tbl[i].e_ifv));
      chk($sformatf("vec%0d_mem_valid", i), 32'(bus.mem_valid), 32'(tbl[i].e_memv));
      if (tbl[i].e_ifv)  chk($sformatf("vec%0d_if_data", i), bus.if_data, tbl[i].e_ifd);
      if (tbl[i].e_memv) chk($sformatf("vec%0d_mem_data", i), bus.mem_data, tbl[i].e_memd);
    end

    // Holding slot drained and refilled on the same edge keeps valid high.
    @(negedge clk); s_rst = 0; s_wr_en = 1; s_wr_data = 32'hA;
    @(negedge clk); s_wr_en = 0;
    #2;
    chk("slot_full_valid", 32'(s_valid), 1);
    chk("slot_full_free", 32'(s_free), 0);
    @(negedge clk); s_rd_ready = 1; s_wr_en = 1; s_wr_data = 32'hB;
    #2;
    chk("slot_drain_free", 32'(s_free), 1);
    @(negedge clk); s_wr_en = 0; s_rd_ready = 0;
    #2;
    chk("slot_refill_valid", 32'(s_valid), 1);
    chk("slot_refill_data", s_data, 32'hB);
    @(negedge clk); s_rd_ready = 1;
    @(negedge clk); s_rd_ready = 0;
    #2;
    chk("slot_drained_valid", 32'(s_valid), 0);

    // Randomized run against the model.
    @(negedge clk); drive(1, 0, 0, 0, 1, 1);
    @(negedge clk); drive(1, 0, 0, 0, 1, 1);
    model_reset();
    for (int c = 0; c < 600; c++) begin
      logic        r, rv, rs, ir, mr, erdy, blocked;
      logic [31:0] resp;
      bit          ready[2], byp[2], ev[2];
      logic [31:0] ed[2];
      @(negedge clk);
      r = ($urandom_range(0, 79) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 1));
      ir = ($urandom_range(0, 3) != 0);
      mr = ($urandom_range(0, 2) != 0);
      resp = $urandom;
      drive(r, rv, rs, resp, ir, mr);
      #2;
      ready[0] = ir; ready[1] = mr;
      blocked = 0;
      foreach (inflight[k]) if (inflight[k] == int'(rs)) blocked = 1;
      erdy = (!m_v[rs] || ready[rs]) && !blocked;
      for (int d = 0; d < 2; d++) begin
        byp[d] = BYP && (inflight.size() > 0) && (inflight[0] == d) && !m_v[d] && ready[d];
        ev[d]  = m_v[d] || byp[d];
        ed[d]  = byp[d] ? resp : m_d[d];
      end
      chk("rnd_req_ready", 32'(bus.req_ready), 32'(erdy));
      chk("rnd_if_valid", 32'(bus.if_valid), 32'(ev[0]));
      chk("rnd_mem_valid", 32'(bus.mem_valid), 32'(ev[1]));
      if (ev[0]) chk("rnd_if_data", bus.if_data, ed[0]);
      if (ev[1]) chk("rnd_mem_data", bus.mem_data, ed[1]);
      if (r) begin
        model_reset();
      end else begin
        for (int d = 0; d < 2; d++) begin
          if ((inflight.size() > 0) && (inflight[0] == d) && !byp[d]) begin
            m_v[d] = 1; m_d[d] = resp;
          end else if (m_v[d] && ready[d]) begin
            m_v[d] = 0;
          end
        end
        inflight.delete();
        if (rv && erdy) inflight.push_back(int'(rs));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
